// File: rtl/seq_accumulator_if.sv
// rtl/seq_accumulator_if.sv - operation handshake and result bundle for seq_accumulator
interface seq_accumulator_if #(
    parameter int WIDTH = 11
);
    logic             op_valid;
    logic             op_ready;
    logic [2:0]       op_code;
    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] acc;
    logic             result_valid;
    logic             overflow;
    logic             busy;

    modport master (
        output op_valid, op_code, operand,
        input  op_ready, acc, result_valid, overflow, busy
    );

    modport slave (
        input  op_valid, op_code, operand,
        output op_ready, acc, result_valid, overflow, busy
    );
endinterface

// File: rtl/seq_accumulator.sv
// rtl/seq_accumulator.sv - accumulator with LOAD/ADD/SUB/CLEAR and shift-add MUL; SEQ_ACCUMULATOR_SAT_EN saturates on overflow
module seq_accumulator #(
    parameter int WIDTH = 11
) (
    input  logic               clk,
    input  logic               reset,
    seq_accumulator_if.slave   bus
);
    localparam int MW = WIDTH - 1;
    localparam int PW = 2 * MW;
    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_ADD   = 3'b001;
    localparam logic [2:0] OP_SUB   = 3'b010;
    localparam logic [2:0] OP_MUL   = 3'b011;
    localparam logic [2:0] OP_CLEAR = 3'b100;

    // Largest legal magnitude, its negative, and the forbidden most-negative code
    localparam logic [WIDTH-1:0] MAX_POS  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MAX_NEG  = {1'b1, {(WIDTH-2){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CW-1:0]    LAST_CNT = CW'(WIDTH - 2);

    typedef enum logic [1:0] {IDLE, MUL_RUN, MUL_FIX} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic             rv_q, rv_d;
    logic [MW-1:0]    mcand_q, mcand_d;
    logic [MW-1:0]    mplier_q, mplier_d;
    logic             sign_q, sign_d;
    logic [PW-1:0]    product_q, product_d;
    logic [CW-1:0]    count_q, count_d;

    logic [WIDTH:0]   acc_x, opd_x, sum;
    logic             sum_ok;
    logic [PW-1:0]    addend;
    logic [WIDTH-1:0] pmag, mul_res;
    logic             mul_ovf;

    // Magnitude of a legal two's-complement value; the most-negative code wraps to 0
    function automatic logic [MW-1:0] mag(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] t;
        t = v[WIDTH-1] ? (~v + 1'b1) : v;
        return t[MW-1:0];
    endfunction

    assign bus.op_ready     = (state_q == IDLE);
    assign bus.busy         = (state_q != IDLE);
    assign bus.acc          = acc_q;
    assign bus.result_valid = rv_q;
    assign bus.overflow     = ovf_q;

    // Arithmetic helpers: one-bit-wider add/sub with range test, and the MUL step/finish values
    always_comb begin
        acc_x   = {acc_q[WIDTH-1], acc_q};
        opd_x   = {bus.operand[WIDTH-1], bus.operand};
        sum     = (bus.op_code == OP_SUB) ? (acc_x - opd_x) : (acc_x + opd_x);
        sum_ok  = (sum[WIDTH] == sum[WIDTH-1]) && (sum[WIDTH-1:0] != MOST_NEG);
        addend  = {{(PW-MW){1'b0}}, mcand_q} << count_q;
        mul_ovf = |product_q[PW-1:WIDTH-1];
        pmag    = {1'b0, product_q[MW-1:0]};
        mul_res = sign_q ? (~pmag + 1'b1) : pmag;
    end

    // Next-state and datapath decisions for the three-state controller
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        rv_d      = 1'b0;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        sign_d    = sign_q;
        product_d = product_q;
        count_d   = count_q;
        case (state_q)
            IDLE: begin
                if (bus.op_valid) begin
                    rv_d = 1'b1;
                    case (bus.op_code)
                        OP_LOAD: begin
                            if (bus.operand == MOST_NEG) begin
                                acc_d = '0;
                                ovf_d = 1'b1;
                            end else begin
                                acc_d = bus.operand;
                                ovf_d = 1'b0;
                            end
                        end
                        OP_ADD, OP_SUB: begin
                            if (sum_ok) begin
                                acc_d = sum[WIDTH-1:0];
                            end else begin
                                ovf_d = 1'b1;
`ifdef SEQ_ACCUMULATOR_SAT_EN
                                acc_d = sum[WIDTH] ? MAX_NEG : MAX_POS;
`else
                                acc_d = acc_q;
`endif
                            end
                        end
                        OP_MUL: begin
                            rv_d      = 1'b0;
                            mcand_d   = mag(acc_q);
                            mplier_d  = mag(bus.operand);
                            sign_d    = acc_q[WIDTH-1] ^ bus.operand[WIDTH-1];
                            product_d = '0;
                            count_d   = '0;
                            state_d   = MUL_RUN;
                        end
                        OP_CLEAR: begin
                            acc_d = '0;
                            ovf_d = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            MUL_RUN: begin
                if (mplier_q[0]) begin
                    product_d = product_q + addend;
                end
                mplier_d = mplier_q >> 1;
                count_d  = count_q + 1'b1;
                if (count_q == LAST_CNT) begin
                    state_d = MUL_FIX;
                end
            end
            MUL_FIX: begin
                if (mul_ovf) begin
                    ovf_d = 1'b1;
`ifdef SEQ_ACCUMULATOR_SAT_EN
                    acc_d = sign_q ? MAX_NEG : MAX_POS;
`else
                    acc_d = acc_q;
`endif
                end else begin
                    acc_d = mul_res;
                end
                rv_d    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any MUL in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            rv_q      <= 1'b0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            sign_q    <= 1'b0;
            product_q <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
            rv_q      <= rv_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            sign_q    <= sign_d;
            product_q <= product_d;
            count_q   <= count_d;
        end
    end
endmodule

// File: tb/tb_seq_accumulator.sv
// tb/tb_seq_accumulator.sv - directed self-checking bench for seq_accumulator
module tb_seq_accumulator;
    localparam int W = 11;
    localparam logic [2:0] LOAD = 3'b000, ADD = 3'b001, SUB = 3'b010,
                           MUL = 3'b011, CLR = 3'b100, NOP = 3'b101;
`ifdef SEQ_ACCUMULATOR_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    int   lat, ready_low, pulses;

    seq_accumulator_if #(.WIDTH(W)) bus();

    seq_accumulator #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present an op and wait through its accept edge; op_valid stays high
    task automatic drive(input logic [2:0] code, input logic [W-1:0] val);
        bus.op_valid = 1'b1;
        bus.op_code  = code;
        bus.operand  = val;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.op_valid = 1'b0;
    endtask

    // Issue MUL, keep op_valid high with a different op and operand, measure latency
    task automatic run_mul(input logic [W-1:0] val, output int l, output int rl);
        drive(MUL, val);
        bus.op_code = ADD;
        bus.operand = ~val;
        l  = 0;
        rl = 0;
        while (!bus.result_valid && l < 30) begin
            if (!bus.op_ready) rl++;
            @(posedge clk);
            #1;
            l++;
        end
        idle();
    endtask

    initial begin
        bus.op_valid = 1'b0;
        bus.op_code  = 3'b000;
        bus.operand  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_acc",   32'(bus.acc), 32'h0);
        check("rst_ovf",   32'(bus.overflow), 32'h0);
        check("rst_rv",    32'(bus.result_valid), 32'h0);
        check("rst_busy",  32'(bus.busy), 32'h0);
        check("rst_ready", 32'(bus.op_ready), 32'h1);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Test 1: back-to-back LOAD 300, ADD 200
        drive(LOAD, 11'd300);
        check("t1_rv_load", 32'(bus.result_valid), 32'h1);
        check("t1_acc_load", 32'(bus.acc), 32'd300);
        drive(ADD, 11'd200);
        check("t1_rv_add", 32'(bus.result_valid), 32'h1);
        check("t1_acc_add", 32'(bus.acc), 32'h1F4);
        idle();
        @(posedge clk);
        #1;
        check("t1_rv_drop", 32'(bus.result_valid), 32'h0);
        check("t1_ovf", 32'(bus.overflow), 32'h0);

        // Test 2: positive overflow
        drive(LOAD, 11'd1000);
        drive(ADD, 11'd100);
        idle();
        check("t2_ovf", 32'(bus.overflow), 32'h1);
        check("t2_acc", 32'(bus.acc), SAT ? 32'h3FF : 32'd1000);

        // Test 3: result lands on the illegal most-negative code, then CLEAR
        drive(LOAD, 11'h600);
        check("t3_ovf_cleared_by_load", 32'(bus.overflow), 32'h0);
        drive(SUB, 11'h200);
        idle();
        check("t3_ovf", 32'(bus.overflow), 32'h1);
        check("t3_acc", 32'(bus.acc), SAT ? 32'h401 : 32'h600);
        drive(CLR, 11'h123);
        idle();
        check("t3_clr_acc", 32'(bus.acc), 32'h0);
        check("t3_clr_ovf", 32'(bus.overflow), 32'h0);

        // Edge values: exactly +1023 is legal; -1000 + -24 = -1024 is not
        drive(LOAD, 11'd1000);
        drive(ADD, 11'd23);
        idle();
        check("edge_max_acc", 32'(bus.acc), 32'h3FF);
        check("edge_max_ovf", 32'(bus.overflow), 32'h0);
        drive(LOAD, 11'h418);
        drive(ADD, 11'h7E8);
        idle();
        check("edge_neg_ovf", 32'(bus.overflow), 32'h1);
        check("edge_neg_acc", 32'(bus.acc), SAT ? 32'h401 : 32'h418);
        drive(ADD, 11'd5);
        check("sticky_ovf", 32'(bus.overflow), 32'h1);
        check("sticky_acc", 32'(bus.acc), SAT ? 32'h406 : 32'h41D);
        drive(NOP, 11'd77);
        idle();
        check("nop_rv", 32'(bus.result_valid), 32'h1);
        check("nop_acc", 32'(bus.acc), SAT ? 32'h406 : 32'h41D);
        drive(LOAD, 11'h400);
        idle();
        check("load_most_neg_acc", 32'(bus.acc), 32'h0);
        check("load_most_neg_ovf", 32'(bus.overflow), 32'h1);

        // Test 4: -25 * 40 = -1000 with op_valid held high while busy
        drive(LOAD, 11'h7E7);
        run_mul(11'd40, lat, ready_low);
        check("t4_latency", 32'(lat), 32'd11);
        check("t4_ready_low", 32'(ready_low), 32'd11);
        check("t4_acc", 32'(bus.acc), 32'h418);
        check("t4_ovf", 32'(bus.overflow), 32'h0);
        @(posedge clk);
        #1;
        check("t4_rv_one_cycle", 32'(bus.result_valid), 32'h0);
        check("t4_not_queued", 32'(bus.acc), 32'h418);

        // Test 5: MUL overflow, then zero times negative gives +0
        drive(LOAD, 11'd100);
        run_mul(11'd11, lat, ready_low);
        check("t5_ovf", 32'(bus.overflow), 32'h1);
        check("t5_acc", 32'(bus.acc), SAT ? 32'h3FF : 32'd100);
        drive(LOAD, 11'd0);
        run_mul(11'h7F9, lat, ready_low);
        check("t5_zero_acc", 32'(bus.acc), 32'h0);
        check("t5_zero_ovf", 32'(bus.overflow), 32'h0);

        // Sign combinations: (-5)*(-6)=30, 7*(-3)=-21
        drive(LOAD, 11'h7FB);
        run_mul(11'h7FA, lat, ready_low);
        check("mul_nn", 32'(bus.acc), 32'd30);
        drive(LOAD, 11'd7);
        run_mul(11'h7FD, lat, ready_low);
        check("mul_pn", 32'(bus.acc), 32'h7EB);
        check("mul_pn_lat", 32'(lat), 32'd11);

        // Test 6: reset on the 5th MUL_RUN cycle aborts the multiply
        drive(LOAD, 11'd9);
        drive(MUL, 11'd9);
        idle();
        repeat (4) @(posedge clk);
        #1;
        check("t6_busy_mid", 32'(bus.busy), 32'h1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("t6_acc", 32'(bus.acc), 32'h0);
        check("t6_ready", 32'(bus.op_ready), 32'h1);
        check("t6_busy", 32'(bus.busy), 32'h0);
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            if (bus.result_valid) pulses++;
            @(posedge clk);
            #1;
        end
        check("t6_no_pulse", 32'(pulses), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/seq_accumulator.md
Name: seq_accumulator

Overview:
- Sequential arithmetic core sitting directly downstream of the signed-magnitude to two's-complement converter.
- Consumes one converted two's-complement operand per handshake and applies an opcode to a WIDTH-bit accumulator: LOAD, ADD, SUB, MUL or CLEAR.
- MUL is a multi-cycle shift-add unit. All other opcodes complete in a single cycle.
- The accumulator is kept within the symmetric range ±(2^(WIDTH-1)-1), so it always converts back to signed-magnitude with no loss.

Parameters:
WIDTH, 11, operand/accumulator width in bits, two's complement

Ports:
clk  input  1  clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
op_valid  input  1  operand/opcode present
op_ready  output  1  block can accept an operation this cycle
op_code  input  3  000 LOAD, 001 ADD, 010 SUB, 011 MUL, 100 CLEAR, 101-111 NOP
operand  input  WIDTH  two's-complement operand from converter
acc  output  WIDTH  current accumulator value, two's complement
result_valid  output  1  one-cycle pulse after each completed operation
overflow  output  1  sticky out-of-range flag
busy  output  1  high while MUL is in progress

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high, named reset.
- Reset values: acc=0, overflow=0, result_valid=0, busy=0, op_ready=1, state=IDLE. Multiplier registers and counter are cleared.
- Handshake: an operation is accepted on a rising edge where op_valid && op_ready. op_ready = (state==IDLE). An op_valid asserted while op_ready is low is ignored and is not queued.
- States: IDLE, MUL_RUN, MUL_FIX.
- Result range: an accumulator value is legal iff it lies in [-(2^(WIDTH-1)-1), 2^(WIDTH-1)-1]. The most-negative code, -2^(WIDTH-1), is illegal and counts as overflow.
- Overflow on any op: acc keeps its previous value and overflow is set. overflow is sticky and is cleared only by LOAD, CLEAR or reset.

IDLE, single-cycle ops (accept edge N):
- LOAD: acc<=operand, overflow<=0. If operand equals -2^(WIDTH-1), acc<=0 and overflow<=1.
- ADD / SUB: compute the true result at WIDTH+1 bits, acc±operand, then apply the range rule above.
- CLEAR: acc<=0, overflow<=0.
- NOP: no state change.
- result_valid is high during the cycle after edge N, for exactly one cycle. State stays IDLE. Back-to-back accepts are allowed, one per cycle.

MUL (accept edge N):
- At edge N, capture:
  - mcand = |acc| (WIDTH-1 bits),
  - mplier = |operand| (WIDTH-1 bits),
  - sign = acc[MSB]^operand[MSB],
  - product (2*(WIDTH-1) bits) = 0,
  - count = 0.
- Go to MUL_RUN. busy=1, op_ready=0.
- MUL_RUN, once per cycle: if mplier[0] then product += mcand<<count; then mplier>>=1, count++. After WIDTH-1 iterations (edges N+1..N+WIDTH-1), go to MUL_FIX.
- MUL_FIX, edge N+WIDTH:
  - If product > 2^(WIDTH-1)-1, apply the overflow rule.
  - Otherwise acc <= sign ? -product : product. A zero product always gives +0.
  - Go to IDLE, busy=0.
  - result_valid is high in the following cycle.
- Total latency for W=11: accept to result_valid is 11 cycles, versus 1 cycle for single-cycle ops.

Boundary cases:
- Operand -0 cannot arrive from the converter. Any operand is still treated purely as two's complement.
- Reset in any state (including mid-MUL) aborts the operation: acc=0, no result_valid pulse, op_ready=1 in the cycle after the reset edge.
- The operand is sampled only at the accept edge. Later changes on operand do not affect an in-progress MUL.

Optional Feature:
Macro SEQ_ACCUMULATOR_SAT_EN.
- Defined: on overflow, acc saturates to +(2^(WIDTH-1)-1) or -(2^(WIDTH-1)-1) according to the sign of the true result; overflow is still set.
- Undefined: acc holds its previous value on overflow, as specified above.

Test Plan:
1. LOAD 300, then ADD 200 on consecutive cycles -> acc=500 (0x1F4), overflow=0, two result_valid pulses each exactly 1 cycle after accept.
2. LOAD 1000, then ADD 100 -> overflow=1. Without SAT: acc=1000. With SAT: acc=1023 (0x3FF).
3. LOAD -512 (0x600), then SUB 512 -> true -1024 is illegal, overflow=1. Without SAT: acc=0x600. With SAT: acc=-1023 (0x401). A following CLEAR sets acc=0 and overflow=0.
4. LOAD -25 (0x7E7), then MUL 40 -> acc=-1000 (0x418). op_ready low for 11 cycles; result_valid exactly 11 cycles after accept; op_valid held high during busy is not accepted.
5. LOAD 100, then MUL 11 -> product 1100 gives overflow=1. Without SAT: acc=100. With SAT: acc=1023. Then LOAD 0 and MUL -7 -> acc=0 (+0), overflow=0.
6. LOAD 9, MUL 9, assert reset on the 5th MUL_RUN cycle -> next cycle acc=0, op_ready=1, busy=0, no result_valid pulse.
